rr_reg_arbiter: RTL and testbench
=================================

// Module: rr_reg_arbiter
// PURPOSE
//  Round-robin arbiter sharing one DW-bit output holding register among N
//  requesters. Each requester uses a valid/ready handshake. The winner's word
//  is captured into the register and presented downstream under valid/ready.
//  Sits in front of a shared pipeline register or sink port wherever several
//  sources feed one resource.
// PARAMETERS
//  N   4   number of requesters (>=2)
//  DW  32  data width per requester
// PORTS
//  clk        in   1     single clock; all flops rising-edge
//  nreset     in   1     asynchronous active-low reset
//  en         in   N     per-requester enable; 0 masks that requester from grant
//  req_valid  in   N     requester i has a word on req_data[i*DW +: DW]
//  req_data   in   N*DW  packed requester data, requester 0 in LSBs
//  req_ready  out  N     one-hot: requester i's word accepted this cycle
//  out_valid  out  1     holding register contains a word
//  out_data   out  DW    holding register contents
//  out_grant  out  N     one-hot source of out_data; 0 when out_valid=0
//  out_ready  in   1     downstream accepts out_data this cycle
// BEHAVIOUR
//  - Reset (async, nreset=0): out_valid=0, out_data=0, out_grant=0, rr pointer=0.
//    req_ready=0 while in reset. A held word is dropped.
//  - load = ~out_valid | out_ready. The register accepts a new word only when load=1.
//  - eligible[i] = req_valid[i] & en[i]. The winner is the first eligible index
//    at or after ptr, scanning upward and wrapping mod N.
//  - req_ready[w] = load & |eligible, for winner w only. req_ready is
//    combinational from inputs and state. It never depends on req_ready.
//  - On load & |eligible: out_data<=req_data[w], out_grant<=onehot(w),
//    out_valid<=1, ptr<=(w+1) mod N (wraps N-1 -> 0).
//  - On load & ~|eligible: out_valid<=0, out_grant<=0. out_data holds its value.
//    ptr is unchanged.
//  - out_ready=0 with out_valid=1: the register and out_grant are frozen and
//    req_ready=0.
//  - Latency: accepted at cycle t -> out_valid at t+1. Full throughput: one
//    word per cycle when out_ready stays high.
//  - Simultaneous drain and fill in the same cycle: the new word replaces the
//    old with no bubble.
//  - en changes affect only future grants. A held word is never withdrawn.
//  - Requesters must hold req_valid/req_data until req_ready. Dropping
//    req_valid early is legal: that requester is simply not granted.
//  - ptr width is clog2(N). For non-power-of-2 N, ptr never reaches >=N.
// STRUCTURE
//  - Shared include: clog2 constant function only. No other shared constants
//    are needed.
//  - Sub-module arb_rr_pick (combinational): inputs eligible[N] and ptr;
//    outputs one-hot grant[N] and index. Uses a double-width masked priority
//    encoder.
//  - The top level holds the ptr register, the holding register, out_grant
//    and the load logic.
// TESTING
//  1 Reset: nreset=0 mid-transfer with out_valid=1 -> out_valid=0, out_grant=0,
//    out_data=0 immediately. After release, all 4 valid -> req0 granted first.
//  2 Rotation: N=4, all valid, en=4'hF, out_ready=1 -> grants 0,1,2,3,0 on
//    consecutive cycles; out_data follows one cycle later.
//  3 Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> req_ready=0 and
//    out_data stable. Raising out_ready -> next winner loads the same cycle,
//    no bubble.
//  4 Masking: en=4'b1011, all valid, ptr=2 -> req3 granted, then req0, req1,
//    req3; req2 is never granted.
//  5 Sparse/wrap: only req1 valid with ptr=2 -> req1 granted (wrap). ptr=2
//    afterwards. Idle cycle -> out_valid drops to 0.
//  6 Random: random valid/en/out_ready for 10k cycles against a scoreboard
//    model -> no loss or duplication. A continuously eligible requester waits
//    at most N-1 accepted grants.

Source files
------------

// File: rtl/rr_reg_arbiter_pkg.sv
// Shared helpers for the round-robin register arbiter.
// Holds only the constant clog2 used to size the rr pointer.
package rr_reg_arbiter_pkg;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/rr_reg_arbiter_pick.sv
// Combinational round-robin pick: first eligible index at or after ptr.
// The doubled vector lets a plain priority scan handle the wrap.
module arb_rr_pick
   import rr_reg_arbiter_pkg::*;
#(
   parameter int N  = 4,
   parameter int PW = 2
) (
   input  logic [N-1:0]  eligible,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] index
);

   logic [N-1:0]   hi_mask;
   logic [2*N-1:0] dbl;
   logic           found;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         hi_mask[i] = (i >= int'(ptr));
      end
   end

   // Lower copy masked below ptr; upper copy supplies the wrapped indices
   assign dbl = {eligible, eligible & hi_mask};

   always_comb begin
      grant = '0;
      index = '0;
      found = 1'b0;
      for (int j = 0; j < 2*N; j++) begin
         if (!found && dbl[j]) begin
            found = 1'b1;
            index = PW'(j % N);
            grant[j % N] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter feeding one shared DW-bit holding register.
// Winner is captured on load; downstream drains it under valid/ready.
module rr_reg_arbiter
   import rr_reg_arbiter_pkg::*;
#(
   parameter int N  = 4,
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            nreset,
   input  logic [N-1:0]    en,
   input  logic [N-1:0]    req_valid,
   input  logic [N*DW-1:0] req_data,
   output logic [N-1:0]    req_ready,
   output logic            out_valid,
   output logic [DW-1:0]   out_data,
   output logic [N-1:0]    out_grant,
   input  logic            out_ready
);

   localparam int PW = clog2(N);

   logic [N-1:0]  elig;
   logic [N-1:0]  pick_grant;
   logic [PW-1:0] pick_idx;
   logic          any_elig;
   logic          load;
   logic          accept;

   logic          valid_q, valid_d;
   logic [DW-1:0] data_q,  data_d;
   logic [N-1:0]  grant_q, grant_d;
   logic [PW-1:0] ptr_q,   ptr_d;

   assign elig     = req_valid & en;
   assign any_elig = |elig;
   assign load     = ~valid_q | out_ready;
   assign accept   = load & any_elig;

   arb_rr_pick #(
      .N  (N),
      .PW (PW)
   ) u_pick (
      .eligible (elig),
      .ptr      (ptr_q),
      .grant    (pick_grant),
      .index    (pick_idx)
   );

   // Ready is suppressed while reset is asserted
   assign req_ready = (accept & nreset) ? pick_grant : '0;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      if (load) begin
         valid_d = any_elig;
         grant_d = any_elig ? pick_grant : '0;
         if (any_elig) begin
            data_d = req_data[pick_idx*DW +: DW];
            ptr_d  = (pick_idx == PW'(N - 1)) ? '0 : pick_idx + PW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         grant_q <= '0;
         ptr_q   <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_grant = grant_q;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Bench for rr_reg_arbiter: directed scenarios plus a long random run
// against a queue-free behavioural model and per-source sequence scoreboard.
module tb_rr_reg_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            nreset;
   logic [N-1:0]    en_r;
   logic [N-1:0]    val_r;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            out_valid;
   logic [DW-1:0]   out_data;
   logic [N-1:0]    out_grant;
   logic            ordy_r;

   rr_reg_arbiter #(.N(N), .DW(DW)) dut (
      .clk       (clk),
      .nreset    (nreset),
      .en        (en_r),
      .req_valid (val_r),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_grant (out_grant),
      .out_ready (ordy_r)
   );

   always #5 clk = ~clk;

   int seq [N];
   int sb_seq [N];
   int wcnt [N];
   bit sb_on;

   function automatic logic [DW-1:0] word(input int i);
      return {8'(i), 24'(seq[i])};
   endfunction

   always_comb begin
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = word(i);
   end

   // Behavioural model state
   bit            m_valid;
   logic [DW-1:0] m_data;
   logic [N-1:0]  m_grant;
   int            m_ptr;
   logic [N-1:0]  rr_seen;

   int n_chk;
   int n_fail;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 0;
      m_data  = '0;
      m_grant = '0;
      m_ptr   = 0;
   endtask

   // One clock: inputs already driven; check ready, advance, check outputs
   task automatic step();
      logic [N-1:0] elig;
      logic [N-1:0] exp_rr;
      bit ld;
      int w, idx;
      elig = val_r & en_r;
      #1;
      ld = !m_valid || ordy_r;
      w = -1;
      if (ld) begin
         for (int k = 0; k < N; k++) begin
            if (w < 0 && elig[(m_ptr + k) % N]) w = (m_ptr + k) % N;
         end
      end
      exp_rr = (w >= 0) ? (N'(1) << w) : '0;
      rr_seen = req_ready;
      chk("req_ready", 64'(req_ready), 64'(exp_rr));
      if (sb_on) begin
         if (out_valid && ordy_r) begin
            idx = -1;
            for (int i = 0; i < N; i++) if (out_grant[i]) idx = i;
            if (idx < 0) idx = 0;
            chk("sb_src", 64'(out_data[31:24]), 64'(idx));
            chk("sb_seq", 64'(out_data[23:0]), 64'(24'(sb_seq[idx])));
            sb_seq[idx]++;
         end
         for (int i = 0; i < N; i++) begin
            if (!elig[i] || w == i) wcnt[i] = 0;
            else if (w >= 0) begin
               wcnt[i]++;
               chk("starve", 64'(wcnt[i] <= N - 1), 64'(1));
            end
         end
      end
      @(posedge clk);
      #1;
      if (ld) begin
         if (w >= 0) begin
            m_valid = 1;
            m_grant = N'(1) << w;
            m_data  = word(w);
            m_ptr   = (w + 1) % N;
            seq[w]++;
         end else begin
            m_valid = 0;
            m_grant = '0;
         end
      end
      @(negedge clk);
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      chk("out_data", 64'(out_data), 64'(m_data));
      chk("out_grant", 64'(out_grant), 64'(m_grant));
   endtask

   task automatic drive(input logic [N-1:0] v, input logic [N-1:0] e,
                        input logic r);
      val_r  = v;
      en_r   = e;
      ordy_r = r;
   endtask

   logic [DW-1:0] held;
   int exp_rot [5] = '{0, 1, 2, 3, 0};
   int exp_msk [4] = '{3, 0, 1, 3};

   initial begin
      n_chk = 0;
      n_fail = 0;
      sb_on = 0;
      for (int i = 0; i < N; i++) begin
         seq[i] = 0;
         wcnt[i] = 0;
      end
      model_reset();
      nreset = 1'b0;
      drive('0, '0, 1'b0);
      repeat (3) @(negedge clk);
      drive(4'hF, 4'hF, 1'b1);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_grant", 64'(out_grant), 64'(0));
      chk("rst_out_data", 64'(out_data), 64'(0));
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      @(negedge clk);
      nreset = 1'b1;

      // Mid-transfer reset: word is held, then dropped asynchronously
      step();
      chk("pre_rst_valid", 64'(out_valid), 64'(1));
      #2;
      nreset = 1'b0;
      #1;
      model_reset();
      chk("async_out_valid", 64'(out_valid), 64'(0));
      chk("async_out_grant", 64'(out_grant), 64'(0));
      chk("async_out_data", 64'(out_data), 64'(0));
      chk("async_req_ready", 64'(req_ready), 64'(0));
      @(negedge clk);
      nreset = 1'b1;

      // Rotation from ptr 0
      for (int k = 0; k < 5; k++) begin
         step();
         chk("rot_ready", 64'(rr_seen), 64'(N'(1) << exp_rot[k]));
         chk("rot_grant", 64'(out_grant), 64'(N'(1) << exp_rot[k]));
         chk("rot_data", 64'(out_data), 64'({8'(exp_rot[k]), 24'(seq[exp_rot[k]] - 1)}));
      end

      // Backpressure for 5 cycles, then release with no bubble
      held = out_data;
      drive(4'hF, 4'hF, 1'b0);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("bp_ready", 64'(rr_seen), 64'(0));
         chk("bp_data", 64'(out_data), 64'(held));
      end
      ordy_r = 1'b1;
      step();
      chk("bp_rel_ready", 64'(rr_seen), 64'(4'b0010));
      chk("bp_rel_valid", 64'(out_valid), 64'(1));
      chk("bp_rel_grant", 64'(out_grant), 64'(4'b0010));

      // Masking with ptr 2
      drive(4'hF, 4'b1011, 1'b1);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("mask_ready", 64'(rr_seen), 64'(N'(1) << exp_msk[k]));
      end

      // Sparse and wrap
      drive(4'b0010, 4'hF, 1'b1);
      step();
      chk("sp_ready0", 64'(rr_seen), 64'(4'b0010));
      chk("sp_ptr0", 64'(m_ptr), 64'(2));
      step();
      chk("wrap_ready", 64'(rr_seen), 64'(4'b0010));
      chk("wrap_ptr", 64'(m_ptr), 64'(2));
      drive('0, 4'hF, 1'b1);
      step();
      chk("idle_valid", 64'(out_valid), 64'(0));
      chk("idle_grant", 64'(out_grant), 64'(0));
      drive(4'hF, 4'hF, 1'b1);
      step();
      chk("ptr2_ready", 64'(rr_seen), 64'(4'b0100));
      drive('0, 4'hF, 1'b1);
      step();

      // Random run with scoreboard
      for (int i = 0; i < N; i++) sb_seq[i] = seq[i];
      sb_on = 1;
      en_r = 4'hF;
      for (int c = 0; c < 10000; c++) begin
         val_r = N'($urandom);
         if ($urandom_range(0, 7) == 0) en_r = N'($urandom);
         ordy_r = ($urandom_range(0, 9) < 7);
         step();
      end
      drive('0, 4'hF, 1'b1);
      step();
      step();
      for (int i = 0; i < N; i++) chk("sb_total", 64'(sb_seq[i]), 64'(seq[i]));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
